aes128_iter_core: RTL and testbench

- Iterative AES-128 encryption engine.
- Wraps the team's combinational round units: subbytes, shiftrow, mixcolumn and KeyGeneration (4-bit round index rc).
- Adds a registered state/key datapath, a round counter, and valid/ready handshakes on input and output.
- Parametrised unroll factor trades area for latency. Sits between the AES APB/register front-end and the result buffer.

---
 rtl/aes128_iter_core.sv | 276 +++++++++++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// -----------------------------------------------------------------------------
// aes128_iter_core
//   Iterative AES-128 encryption engine. A block is accepted with a valid/ready
//   handshake, then RPC rounds are computed per clock until round 10 completes.
//   The ciphertext is held on out_data with out_valid until the downstream
//   accepts it.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. Valid and its payload stay stable until that
//   edge. in_ready and out_valid depend only on the FSM state.
//
// Parameters
//   RPC    AES rounds per clock. Legal values: 1, 2, 5, 10.
//   CNT_W  Round counter width. 2**CNT_W must be greater than 10.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   plaintext/key offered
//   in_ready   out  core can accept a block (IDLE)
//   in_data    in   128-bit plaintext, byte 0 = [127:120]
//   in_key     in   128-bit cipher key, same byte order
//   out_valid  out  ciphertext available (DONE)
//   out_ready  in   downstream accepts ciphertext
//   out_data   out  128-bit ciphertext
//   busy       out  high while a block is in ROUND
//   dbg_state  out  current FSM state encoding (IDLE=0, ROUND=1, DONE=2)
//
// Build option
//   AES_ITER_ZEROIZE_EN : when defined, state, key and out_data are cleared on
//   the output handshake edge, so out_data reads 0 whenever out_valid is low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module aes128_iter_core #(
    parameter int RPC   = 1,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
        $error("aes128_iter_core: RPC must be 1, 2, 5 or 10");
    end
    if ((2 ** CNT_W) <= 10) begin : g_bad_cnt_w
        $error("aes128_iter_core: CNT_W too small to count to 10");
    end

    // S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ---------------------------------------------------------------- round units
    // Entry b sits at bit offset (255-b)*8, and 255-b == ~b for an 8-bit b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] subbytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Byte n = row n%4, column n/4. Row r rotates left by r columns.
    function automatic logic [127:0] shiftrow(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mixcolumn(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Round key rc from round key rc-1.
    function automatic logic [127:0] KeyGeneration(input logic [3:0] rc, input logic [127:0] k);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(rc), 24'h000000};
        n0  = k[127:96] ^ t;
        n1  = k[95:64]  ^ n0;
        n2  = k[63:32]  ^ n1;
        n3  = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // ---------------------------------------------------------------- state
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_st;
    logic [127:0]       r_key;
    logic [127:0]       r_out;
    logic [CNT_W-1:0]   r_rnd;

    logic               w_accept;
    logic               w_last;
    logic               w_deliver;
    logic               w_rnd_bad;
    logic               w_rnd_end;
    logic [127:0]       w_s_nxt;
    logic [127:0]       w_k_nxt;
    logic [127:0]       w_t;
    logic [3:0]         w_rc;

    // Rounds rnd .. rnd+RPC-1 are finished by this cycle's edge.
    assign w_rnd_end = ((int'(r_rnd) + RPC - 1) == 10);
    assign w_rnd_bad = (r_rnd == '0) || ((int'(r_rnd) + RPC - 1) > 10);

    // ---------------------------------------------------------------- round chain
    always_comb begin
        w_s_nxt = r_st;
        w_k_nxt = r_key;
        w_t     = '0;
        w_rc    = '0;
        for (int i = 0; i < RPC; i++) begin
            w_rc    = 4'(r_rnd) + 4'(i);
            w_k_nxt = KeyGeneration(w_rc, w_k_nxt);
            w_t     = shiftrow(subbytes(w_s_nxt));
            // The final round skips MixColumns.
            if (w_rc != 4'd10) w_t = mixcolumn(w_t);
            w_s_nxt = w_t ^ w_k_nxt;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_deliver   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                busy = 1'b1;
                if (w_rnd_bad) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rnd_end) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    // r_out is separate from r_st so the last ciphertext survives the initial
    // whitening of the next accepted block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st  <= '0;
            r_key <= '0;
            r_out <= '0;
            r_rnd <= '0;
        end else begin
            if (w_accept) begin
                r_st  <= in_data ^ in_key;
                r_key <= in_key;
                r_rnd <= CNT_W'(1);
            end
            if (r_state == S_ROUND && !w_rnd_bad) begin
                r_st  <= w_s_nxt;
                r_key <= w_k_nxt;
                if (w_last) begin
                    // Park the counter on 10 rather than stepping past it.
                    r_rnd <= CNT_W'(10);
                    r_out <= w_s_nxt;
                end else begin
                    r_rnd <= r_rnd + CNT_W'(RPC);
                end
            end
`ifdef AES_ITER_ZEROIZE_EN
            if (w_deliver) begin
                r_st  <= '0;
                r_key <= '0;
                r_out <= '0;
            end
`endif
        end
    end

    assign out_data  = r_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aes128_iter_core.sv
`timescale 1ns/1ps

module tb_aes128_iter_core;

    localparam int RPC = 1;
    localparam int LAT = 1 + 10 / RPC;   // edges from accept to out_valid

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    // ------------------------------------------------------------ clock/reset
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    aes128_iter_core #(.RPC(RPC), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------ scoreboard
    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ driver tasks
    // Steps one edge at a time (sampling 1 ns after it) until out_valid is seen.
    task automatic wait_valid(output int edges);
        edges = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                edges = n;
                return;
            end
        end
        edges = 1000;
    endtask

    // Offers one block, returns once out_valid is up; checks latency and data.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp, input string tag);
        int e;
        in_key   = key;
        in_data  = pt;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, 128'(busy), 128'(1));
        check_eq({tag, "_in_ready_low"}, 128'(in_ready), 128'(0));
        wait_valid(e);
        check_eq({tag, "_latency"}, 128'(1 + e), 128'(LAT));
        check_eq({tag, "_data"}, out_data, exp);
    endtask

    // Completes the output handshake and checks the IDLE return.
    task automatic take_output(input logic [127:0] last_ct, input string tag);
        logic [127:0] exp_after;
`ifdef AES_ITER_ZEROIZE_EN
        exp_after = 128'h0;
`else
        exp_after = last_ct;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        check_eq({tag, "_busy_idle"}, 128'(busy), 128'(0));
        check_eq({tag, "_data_after"}, out_data, exp_after);
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ main
    initial begin
        logic [127:0] held;
        int           e;
        int           pre;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_out_data", out_data, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 C.1 with backpressure on the result.
        run_block(C1_KEY, C1_PT, C1_CT, "c1");
        held = out_data;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check_eq("bp_valid", 128'(out_valid), 128'(1));
            check_eq("bp_data", out_data, held);
            check_eq("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        take_output(C1_CT, "c1_hs");
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_no_accept", 128'(busy), 128'(0));

        // Back-to-back: C.1 then App. B with in_valid held high.
        exp_q.push_back(C1_CT);
        exp_q.push_back(B_CT);
        out_ready = 1'b1;
        in_key    = C1_KEY;
        in_data   = C1_PT;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        check_eq("b2b_first_busy", 128'(busy), 128'(1));
        in_key  = B_KEY;
        in_data = B_PT;
        wait_valid(e);
        check_eq("b2b_first_latency", 128'(1 + e), 128'(LAT));
        check_eq("b2b_first_data", out_data, exp_q.pop_front());
        @(posedge clk); #1;
        check_eq("b2b_hs_in_ready", 128'(in_ready), 128'(1));
        check_eq("b2b_hs_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("b2b_second_busy", 128'(busy), 128'(1));
        wait_valid(e);
        check_eq("b2b_second_latency", 128'(1 + e), 128'(LAT));
        check_eq("b2b_second_data", out_data, exp_q.pop_front());
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("b2b_done_in_ready", 128'(in_ready), 128'(1));
        check_eq("b2b_queue_empty", 128'(exp_q.size()), 128'(0));

        // Reset during round 5 (or the only round cycle for large RPC).
        in_key   = C1_KEY;
        in_data  = C1_PT;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pre = (10 / RPC - 1 < 4) ? (10 / RPC - 1) : 4;
        for (int i = 0; i < pre; i++) begin
            @(posedge clk); #1;
        end
        check_eq("mid_busy_before", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 128'(out_valid), 128'(0));
        check_eq("mid_rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("mid_rst_busy", 128'(busy), 128'(0));
        check_eq("mid_rst_data", out_data, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check_eq("mid_no_valid_pulse", 128'(out_valid), 128'(0));

        // Fresh C.1 after the aborted block.
        run_block(C1_KEY, C1_PT, C1_CT, "c1_again");
        take_output(C1_CT, "c1_again_hs");

        // App. B vector at this build's unroll.
        run_block(B_KEY, B_PT, B_CT, "appb");
        take_output(B_CT, "appb_hs");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
